// File: rtl/gtx_rst_seq_if.sv
// GTX reset-sequencer signal bundle: lane status inputs and the
// per-lane pulse/status outputs driven by the sequencer.
interface gtx_rst_seq_if #(
  parameter int LANES = 4
);
  logic               RESTART;
  logic [LANES-1:0]   TXPLLKDET;
  logic [LANES-1:0]   TXRESETDONE;
  logic [LANES-1:0]   GTXTEST1;
  logic [LANES-1:0]   GTXRESET;
  logic [LANES-1:0]   LANE_READY;
  logic [LANES-1:0]   LANE_FAIL;
  logic               ALL_READY;
  logic [4*LANES-1:0] RETRY_CNT;

  modport master (
    input  RESTART,
    input  TXPLLKDET,
    input  TXRESETDONE,
    output GTXTEST1,
    output GTXRESET,
    output LANE_READY,
    output LANE_FAIL,
    output ALL_READY,
    output RETRY_CNT
  );

  modport slave (
    output RESTART,
    output TXPLLKDET,
    output TXRESETDONE,
    input  GTXTEST1,
    input  GTXRESET,
    input  LANE_READY,
    input  LANE_FAIL,
    input  ALL_READY,
    input  RETRY_CNT
  );
endinterface

// File: rtl/gtx_rst_seq.sv
// Multi-lane GTX post-lock sequencer: settle, GTXTEST1 pulse,
// reset-done check with timeout and GTXRESET retries.
module gtx_rst_seq #(
  parameter int LANES          = 4,
  parameter int CNT_W          = 16,
  parameter int WAIT_CYCLES    = 1023,
  parameter int PULSE_CYCLES   = 256,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int GTXRST_CYCLES  = 8,
  parameter int MAX_RETRY      = 3
) (
  input logic           REFCLK,
  input logic           RESET,
  gtx_rst_seq_if.master bus
);
  typedef enum logic [2:0] {
    WAIT_LOCK, SETTLE, PULSE, CHECK,
    GTXRST, READY, FAILED
  } state_t;

  localparam logic [CNT_W-1:0] WAIT_T =
    CNT_W'(WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_T =
    CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIME_T =
    CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GRST_T =
    CNT_W'(GTXRST_CYCLES - 1);
  localparam logic [3:0] RETRY_MAX = 4'(MAX_RETRY);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           st    [LANES];
  state_t           st_n  [LANES];
  logic [CNT_W-1:0] cnt   [LANES];
  logic [CNT_W-1:0] cnt_n [LANES];
  logic [3:0]       rty   [LANES];
  logic [3:0]       rty_n [LANES];

  logic [LANES-1:0]   test_q;
  logic [LANES-1:0]   grst_q;
  logic [LANES-1:0]   rdy_q;
  logic [LANES-1:0]   fail_q;
  logic               all_q;
  logic [4*LANES-1:0] rty_flat;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      st_n[i]  = st[i];
      cnt_n[i] = cnt[i];
      rty_n[i] = rty[i];
      if (bus.RESTART) begin
        st_n[i]  = WAIT_LOCK;
        cnt_n[i] = '0;
        rty_n[i] = '0;
      end else begin
        unique case (st[i])
          WAIT_LOCK: begin
            cnt_n[i] = '0;
            if (bus.TXPLLKDET[i]) st_n[i] = SETTLE;
          end
          SETTLE: begin
            if (!bus.TXPLLKDET[i]) begin
              st_n[i]  = WAIT_LOCK;
              cnt_n[i] = '0;
            end else if (cnt[i] == WAIT_T) begin
              st_n[i]  = PULSE;
              cnt_n[i] = '0;
            end else begin
              cnt_n[i] = cnt[i] + ONE;
            end
          end
          PULSE: begin
            if (!bus.TXPLLKDET[i]) begin
              st_n[i]  = WAIT_LOCK;
              cnt_n[i] = '0;
            end else if (cnt[i] == PULSE_T) begin
              st_n[i]  = CHECK;
              cnt_n[i] = '0;
            end else begin
              cnt_n[i] = cnt[i] + ONE;
            end
          end
          CHECK: begin
            if (!bus.TXPLLKDET[i]) begin
              st_n[i]  = WAIT_LOCK;
              cnt_n[i] = '0;
            end else if (bus.TXRESETDONE[i]) begin
              st_n[i]  = READY;
              cnt_n[i] = '0;
            end else if (cnt[i] == TIME_T) begin
              cnt_n[i] = '0;
              if (rty[i] < RETRY_MAX) begin
                st_n[i]  = GTXRST;
                rty_n[i] = rty[i] + 4'd1;
              end else begin
                st_n[i] = FAILED;
              end
            end else begin
              cnt_n[i] = cnt[i] + ONE;
            end
          end
          // lock is deliberately ignored while the GTX is held in reset
          GTXRST: begin
            if (cnt[i] == GRST_T) begin
              st_n[i]  = WAIT_LOCK;
              cnt_n[i] = '0;
            end else begin
              cnt_n[i] = cnt[i] + ONE;
            end
          end
          READY: begin
            if (!bus.TXPLLKDET[i] || !bus.TXRESETDONE[i])
              st_n[i] = WAIT_LOCK;
          end
          FAILED: st_n[i] = FAILED;
          default: begin
            st_n[i]  = WAIT_LOCK;
            cnt_n[i] = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge REFCLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < LANES; i++) begin
        st[i]  <= WAIT_LOCK;
        cnt[i] <= '0;
        rty[i] <= '0;
      end
      test_q <= '0;
      grst_q <= '0;
      rdy_q  <= '0;
      fail_q <= '0;
      all_q  <= 1'b0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        st[i]     <= st_n[i];
        cnt[i]    <= cnt_n[i];
        rty[i]    <= rty_n[i];
        test_q[i] <= (st_n[i] == PULSE);
        grst_q[i] <= (st_n[i] == GTXRST);
        rdy_q[i]  <= (st_n[i] == READY);
        fail_q[i] <= (st_n[i] == FAILED);
      end
      all_q <= &rdy_q;
    end
  end

  always_comb begin
    rty_flat = '0;
    for (int i = 0; i < LANES; i++)
      rty_flat[4*i +: 4] = rty[i];
  end

  assign bus.GTXTEST1   = test_q;
  assign bus.GTXRESET   = grst_q;
  assign bus.LANE_READY = rdy_q;
  assign bus.LANE_FAIL  = fail_q;
  assign bus.ALL_READY  = all_q;
  assign bus.RETRY_CNT  = rty_flat;
endmodule

// File: tb/tb_gtx_rst_seq.sv
// Bench for gtx_rst_seq: vector table, corner sequences and
// randomized traffic against a countdown-based reference model.
module tb_gtx_rst_seq;
  localparam int L  = 2;
  localparam int W  = 16;
  localparam int P  = 8;
  localparam int T  = 32;
  localparam int G  = 4;
  localparam int MR = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  gtx_rst_seq_if #(.LANES(L)) bus ();

  gtx_rst_seq #(
    .LANES(L), .CNT_W(16), .WAIT_CYCLES(W),
    .PULSE_CYCLES(P), .TIMEOUT_CYCLES(T),
    .GTXRST_CYCLES(G), .MAX_RETRY(MR)
  ) dut (
    .REFCLK(clk),
    .RESET(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  function automatic logic [16:0] outs();
    return {bus.GTXTEST1, bus.GTXRESET, bus.LANE_READY,
            bus.LANE_FAIL, bus.ALL_READY, bus.RETRY_CNT};
  endfunction

  // reference: phase plus cycles-remaining countdown per lane
  typedef enum {IDLE, SETTLING, PULSING, AWAIT,
                RESETTING, UP, DEAD} phase_t;
  phase_t ph    [L];
  int     left  [L];
  int     tries [L];
  logic   e_all;

  function automatic void m_reset();
    for (int i = 0; i < L; i++) begin
      ph[i] = IDLE; left[i] = 0; tries[i] = 0;
    end
    e_all = 1'b0;
  endfunction

  function automatic void m_step();
    logic ar, lk, dn;
    ar = 1'b1;
    for (int i = 0; i < L; i++) ar &= (ph[i] == UP);
    e_all = ar;
    for (int i = 0; i < L; i++) begin
      lk = bus.TXPLLKDET[i];
      dn = bus.TXRESETDONE[i];
      if (bus.RESTART) begin
        ph[i] = IDLE; tries[i] = 0;
      end else begin
        case (ph[i])
          IDLE: if (lk) begin ph[i] = SETTLING; left[i] = W; end
          SETTLING:
            if (!lk) ph[i] = IDLE;
            else begin
              left[i]--;
              if (left[i] == 0) begin ph[i] = PULSING; left[i] = P; end
            end
          PULSING:
            if (!lk) ph[i] = IDLE;
            else begin
              left[i]--;
              if (left[i] == 0) begin ph[i] = AWAIT; left[i] = T; end
            end
          AWAIT:
            if (!lk) ph[i] = IDLE;
            else if (dn) ph[i] = UP;
            else begin
              left[i]--;
              if (left[i] == 0) begin
                if (tries[i] < MR) begin
                  tries[i]++; ph[i] = RESETTING; left[i] = G;
                end else ph[i] = DEAD;
              end
            end
          RESETTING: begin
            left[i]--;
            if (left[i] == 0) ph[i] = IDLE;
          end
          UP: if (!lk || !dn) ph[i] = IDLE;
          default: ;
        endcase
      end
    end
  endfunction

  task automatic m_check();
    logic [1:0] t, g, r, f;
    logic [7:0] rc;
    for (int i = 0; i < L; i++) begin
      t[i] = (ph[i] == PULSING);
      g[i] = (ph[i] == RESETTING);
      r[i] = (ph[i] == UP);
      f[i] = (ph[i] == DEAD);
      rc[4*i +: 4] = 4'(tries[i]);
    end
    chk("model", 32'(outs()), 32'({t, g, r, f, e_all, rc}));
  endtask

  task automatic tick();
    @(posedge clk);
    m_step();
    #1;
    m_check();
  endtask

  typedef struct {
    logic [1:0] lk, dn;
    logic       rs;
    int         n;
    logic [1:0] t, g, r, f;
    logic       a;
    logic [7:0] rc;
  } vec_t;
  vec_t tbl[$];

  initial begin
    logic [1:0] lk, dn;
    int bad, hi, grst_hi, test_hi, fail_at, ovl, first;
    logic e;

    bus.RESTART = 1'b0;
    bus.TXPLLKDET = '0;
    bus.TXRESETDONE = '0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", 32'(outs()), 32'd0);
    rst = 1'b0;

    // lane0 nominal, then lane1, ALL_READY rise/fall, restart
    tbl.push_back('{2'b01, 2'b00, 1'b0, 1,  2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 8'h00});
    tbl.push_back('{2'b01, 2'b00, 1'b0, 15, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 8'h00});
    tbl.push_back('{2'b01, 2'b00, 1'b0, 1,  2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 8'h00});
    tbl.push_back('{2'b01, 2'b00, 1'b0, 7,  2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 8'h00});
    tbl.push_back('{2'b01, 2'b00, 1'b0, 1,  2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 8'h00});
    tbl.push_back('{2'b01, 2'b00, 1'b0, 4,  2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 8'h00});
    tbl.push_back('{2'b01, 2'b01, 1'b0, 1,  2'b00, 2'b00, 2'b01, 2'b00, 1'b0, 8'h00});
    tbl.push_back('{2'b11, 2'b01, 1'b0, 1,  2'b00, 2'b00, 2'b01, 2'b00, 1'b0, 8'h00});
    tbl.push_back('{2'b11, 2'b01, 1'b0, 15, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0, 8'h00});
    tbl.push_back('{2'b11, 2'b01, 1'b0, 1,  2'b10, 2'b00, 2'b01, 2'b00, 1'b0, 8'h00});
    tbl.push_back('{2'b11, 2'b01, 1'b0, 7,  2'b10, 2'b00, 2'b01, 2'b00, 1'b0, 8'h00});
    tbl.push_back('{2'b11, 2'b01, 1'b0, 1,  2'b00, 2'b00, 2'b01, 2'b00, 1'b0, 8'h00});
    tbl.push_back('{2'b11, 2'b11, 1'b0, 1,  2'b00, 2'b00, 2'b11, 2'b00, 1'b0, 8'h00});
    tbl.push_back('{2'b11, 2'b11, 1'b0, 1,  2'b00, 2'b00, 2'b11, 2'b00, 1'b1, 8'h00});
    tbl.push_back('{2'b11, 2'b01, 1'b0, 1,  2'b00, 2'b00, 2'b01, 2'b00, 1'b1, 8'h00});
    tbl.push_back('{2'b11, 2'b01, 1'b0, 1,  2'b00, 2'b00, 2'b01, 2'b00, 1'b0, 8'h00});
    tbl.push_back('{2'b11, 2'b01, 1'b1, 1,  2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 8'h00});
    tbl.push_back('{2'b00, 2'b00, 1'b0, 2,  2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 8'h00});

    foreach (tbl[k]) begin
      bus.TXPLLKDET   = tbl[k].lk;
      bus.TXRESETDONE = tbl[k].dn;
      bus.RESTART     = tbl[k].rs;
      repeat (tbl[k].n) tick();
      chk($sformatf("vec%0d", k), 32'(outs()),
          32'({tbl[k].t, tbl[k].g, tbl[k].r, tbl[k].f,
               tbl[k].a, tbl[k].rc}));
    end
    bus.RESTART = 1'b0;

    // lock lost mid-pulse, then a 1-cycle glitch while settling
    bad = 0; hi = 0;
    bus.TXRESETDONE = '0;
    for (int i = 0; i < 70; i++) begin
      bus.TXPLLKDET = {1'b0, !(i == 20 || i == 31)};
      tick();
      e = (i >= 16 && i <= 19) || (i >= 48 && i <= 55);
      if (bus.GTXTEST1[0] !== e) bad++;
      if (bus.GTXTEST1[0]) hi++;
    end
    chk("glitch_bad_cycles", bad, 0);
    chk("glitch_high_cycles", hi, 12);
    bus.TXPLLKDET = '0;
    tick();

    // lane0 never sees reset-done: two retries then FAILED
    bus.TXPLLKDET   = 2'b11;
    bus.TXRESETDONE = 2'b10;
    grst_hi = 0; test_hi = 0; fail_at = -1; ovl = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (bus.GTXRESET[0]) grst_hi++;
      if (bus.GTXTEST1[0]) test_hi++;
      if (fail_at < 0 && bus.LANE_FAIL[0]) fail_at = i;
      if ((bus.GTXTEST1 & bus.GTXRESET) != 0) ovl++;
    end
    chk("retry_grst_cycles", grst_hi, 8);
    chk("retry_test_cycles", test_hi, 24);
    chk("fail_time", fail_at, 178);
    chk("fail_retry_cnt", 32'(bus.RETRY_CNT), 32'h02);
    chk("lane1_ready", 32'(bus.LANE_READY), 32'b10);
    chk("test_grst_overlap", ovl, 0);

    bus.TXPLLKDET = 2'b01;
    bus.TXRESETDONE = 2'b00;
    bus.RESTART = 1'b1;
    tick();
    bus.RESTART = 1'b0;
    chk("restart_clear", 32'(outs()), 32'd0);

    // async reset with lane0 in GTXRESET and lane1 in pulse
    for (int i = 0; i < 58; i++) begin
      bus.TXPLLKDET = {(i >= 40), 1'b1};
      tick();
    end
    chk("pre_reset", 32'({bus.GTXRESET, bus.GTXTEST1}),
        32'b0110);
    #2 rst = 1'b1;
    #1 chk("async_reset", 32'(outs()), 32'd0);
    #1 rst = 1'b0;
    m_reset();
    first = -1;
    for (int j = 0; j < 20; j++) begin
      tick();
      if (first < 0 && bus.GTXTEST1 == 2'b11) first = j;
    end
    chk("post_reset_pulse", first, 16);

    // randomized traffic checked against the model each cycle
    for (int c = 0; c < 4000; c++) begin
      lk = bus.TXPLLKDET;
      dn = bus.TXRESETDONE;
      for (int i = 0; i < L; i++) begin
        if (lk[i]) lk[i] = ($urandom_range(0, 99) >= 2);
        else lk[i] = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 29) == 0) dn[i] = ~dn[i];
      end
      bus.TXPLLKDET   = lk;
      bus.TXRESETDONE = dn;
      bus.RESTART     = ($urandom_range(0, 399) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
